cpcis_slot_clk_ctrl: RTL

Parametrised CompactPCI Serial slot controller sitting between the PCIe platform reset, the peripheral-slot presence/clock-enable pins and the PCH clock-request pins. It latches per-slot board presence while the platform is in reset and waits a programmable delay after reset release. It then drives an internally generated sync clock onto the present, unmasked slots, and requests the PCIe reference clock for every present slot. Compared with the fixed 7-slot logic it replaces, it adds a generic slot count, an internal sync-clock divider, a runtime slot mask with glitch-free updates, and a presence-change interrupt.

---
 rtl/cpcis_slot_clk_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpcis_slot_clk_ctrl.sv
// CompactPCI Serial peripheral-slot controller: presence latching under PERST#,
// post-reset delay, glitch-free gated sync clock and PCH clock requests.
`timescale 1ns/1ps
module cpcis_slot_clk_ctrl #(
  parameter int unsigned NUM_SLOTS        = 7,
  parameter int unsigned SYNC_HALF_PERIOD = 3906,
  parameter int unsigned RST_DELAY        = 25
) (
  input  logic                 clk125,
  input  logic                 sys_rst,
  input  logic                 pcie_perst_n,
  input  logic [NUM_SLOTS-1:0] slot_prsnt_n_in,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [NUM_SLOTS-1:0] slot_clken_out,
  output logic [NUM_SLOTS-1:0] slot_clken_oe,
  output logic [NUM_SLOTS-1:0] pch_clk_req_oe,
  output logic [NUM_SLOTS-1:0] prsnt_status,
  output logic                 prsnt_change_irq,
  input  logic                 irq_clear,
  input  logic [4:0]           ltssm,
  output logic                 link_led_n,
  output logic                 run
);

  localparam int unsigned SW = $clog2(SYNC_HALF_PERIOD);
  localparam int unsigned DW = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [4:0] LTSSM_L0  = 5'b01111;
  localparam logic [4:0] LTSSM_L0S = 5'b10101;

  logic                 perst_m, perst_s;
  logic [1:0]           state, state_nx;
  logic [NUM_SLOTS-1:0] presence_latch, latch_nx;
  logic [NUM_SLOTS-1:0] mask_eff, mask_nx;
  logic                 sync_clk, sync_clk_nx;
  logic [SW-1:0]        sync_cnt, sync_cnt_nx;
  logic [DW-1:0]        delay_cnt, delay_cnt_nx;
  logic                 irq_nx;
  logic                 run_nx;

  // Next-state and next-output computation
  always_comb begin
    state_nx     = state;
    latch_nx     = presence_latch;
    mask_nx      = mask_eff;
    sync_clk_nx  = sync_clk;
    sync_cnt_nx  = sync_cnt;
    delay_cnt_nx = delay_cnt;
    irq_nx       = prsnt_change_irq & ~irq_clear;

    case (state)
      ST_HOLD: begin
        latch_nx = ~slot_prsnt_n_in;
        if (latch_nx != presence_latch) irq_nx = 1'b1;
        if (perst_s) begin
          state_nx     = ST_DELAY;
          delay_cnt_nx = '0;
        end
      end
      ST_DELAY: begin
        delay_cnt_nx = delay_cnt + DW'(1);
        if (delay_cnt == DW'(RST_DELAY - 1)) begin
          state_nx    = ST_RUN;
          sync_cnt_nx = '0;
          sync_clk_nx = 1'b0;
          mask_nx     = slot_mask;
        end
      end
      ST_RUN: begin
        if (sync_cnt == SW'(SYNC_HALF_PERIOD - 1)) begin
          sync_cnt_nx = '0;
          sync_clk_nx = ~sync_clk;
          // Mask only changes while the clock is heading low: no runt pulses
          if (sync_clk) mask_nx = slot_mask;
        end else begin
          sync_cnt_nx = sync_cnt + SW'(1);
        end
      end
      default: state_nx = ST_HOLD;
    endcase

    if (!perst_s) state_nx = ST_HOLD;

    run_nx = (state_nx == ST_RUN);
  end

  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      perst_m          <= 1'b0;
      perst_s          <= 1'b0;
      state            <= ST_HOLD;
      presence_latch   <= '0;
      mask_eff         <= '1;
      sync_clk         <= 1'b0;
      sync_cnt         <= '0;
      delay_cnt        <= '0;
      prsnt_change_irq <= 1'b0;
      run              <= 1'b0;
      slot_clken_oe    <= '0;
      slot_clken_out   <= '0;
      pch_clk_req_oe   <= '0;
      prsnt_status     <= '0;
      link_led_n       <= 1'b1;
    end else begin
      perst_m          <= pcie_perst_n;
      perst_s          <= perst_m;
      state            <= state_nx;
      presence_latch   <= latch_nx;
      mask_eff         <= mask_nx;
      sync_clk         <= sync_clk_nx;
      sync_cnt         <= sync_cnt_nx;
      delay_cnt        <= delay_cnt_nx;
      prsnt_change_irq <= irq_nx;
      run              <= run_nx;
      slot_clken_oe    <= run_nx ? latch_nx : '0;
      slot_clken_out   <= run_nx ? (latch_nx & ~mask_nx & {NUM_SLOTS{sync_clk_nx}}) : '0;
      pch_clk_req_oe   <= latch_nx;
      prsnt_status     <= latch_nx;
      link_led_n       <= ~((ltssm == LTSSM_L0) || (ltssm == LTSSM_L0S));
    end
  end

endmodule
